// File: rtl/audio_pkg.sv
// Shared audio types and frame geometry for the I2S transmit path.
package audio_pkg;

    typedef logic signed [15:0] sample_t;

    localparam int SLOT_BITS  = 16;
    localparam int FRAME_BITS = 32;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } tx_state_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit clock divider: bclk toggles every CLK_DIV clk cycles.
module i2s_clk_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    output logic bclk,
    output logic fall_strobe
);

    logic [7:0] cnt;
    logic       wrap;

    assign wrap = (cnt == 8'(CLK_DIV - 1));
    // High in the cycle whose closing edge drives bclk 1->0.
    assign fall_strobe = wrap && bclk;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            bclk <= 1'b0;
        end else if (wrap) begin
            cnt  <= '0;
            bclk <= ~bclk;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// Mono I2S transmitter with a one-sample holding buffer.
// I2S_TX_UNDERRUN_HOLD_EN: underrun frames repeat the last frame instead of silence.
module i2s_tx
    import audio_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    valid,
    input  sample_t sample_in,
    output logic    ready,
    output logic    bclk,
    output logic    lrclk,
    output logic    sdata,
    output logic    underrun,
    output logic    overflow
);

    tx_state_t             state;
    tx_state_t             state_nxt;
    logic [4:0]            b;
    logic [4:0]            b_nxt;
    logic                  fall;
    logic                  load;
    logic                  capture;
    logic                  buf_full;
    sample_t               buf_data;
    logic [FRAME_BITS-1:0] frame;

    i2s_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk        (clk),
        .rst        (rst),
        .bclk       (bclk),
        .fall_strobe(fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            b     <= '0;
        end else begin
            state <= state_nxt;
            b     <= b_nxt;
        end
    end

    // The first falling edge after reset enters slot 0 directly.
    always_comb begin
        state_nxt = state;
        b_nxt     = b;
        load      = 1'b0;
        if (fall) begin
            unique case (state)
                ST_IDLE: begin
                    state_nxt = ST_RUN;
                    b_nxt     = '0;
                    load      = 1'b1;
                end
                ST_RUN: begin
                    b_nxt = b + 5'd1;
                    load  = (b == 5'd31);
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign ready   = !buf_full || load;
    assign capture = valid && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_full <= 1'b0;
            buf_data <= '0;
            frame    <= '0;
            sdata    <= 1'b0;
            lrclk    <= 1'b0;
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            underrun <= load && !buf_full;
            overflow <= valid && !ready;
            if (capture) begin
                buf_data <= sample_in;
            end
            if (load) begin
                // Slot 0 still carries the outgoing frame's LSB.
                sdata    <= frame[0];
                lrclk    <= 1'b0;
                buf_full <= capture;
                if (buf_full) begin
                    frame <= {buf_data, buf_data};
                end else begin
`ifdef I2S_TX_UNDERRUN_HOLD_EN
                    frame <= frame;
`else
                    frame <= '0;
`endif
                end
            end else begin
                if (capture) begin
                    buf_full <= 1'b1;
                end
                if (fall) begin
                    sdata <= frame[~b];
                    lrclk <= b_nxt[4];
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed self-checking bench for i2s_tx at CLK_DIV=2.
module tb_i2s_tx;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [15:0] sample_in;
    logic        ready;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underrun;
    logic        overflow;

    int   checks;
    int   errors;
    int   un_cnt;
    int   ov_cnt;
    logic prev_bclk;
    logic fell;

    i2s_tx #(
        .CLK_DIV(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid),
        .sample_in(sample_in),
        .ready    (ready),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .sdata    (sdata),
        .underrun (underrun),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        prev_bclk = bclk;
        @(posedge clk);
        #1;
        fell = prev_bclk && !bclk;
        if (underrun) un_cnt++;
        if (overflow) ov_cnt++;
    endtask

    task automatic next_slot();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!fell && n < 16);
        if (!fell) begin
            errors++;
            $display("FAIL slot_timeout: no bclk fall within %0d clks", n);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic write(input logic [15:0] s);
        valid     = 1'b1;
        sample_in = s;
        tick();
        valid = 1'b0;
    endtask

    task automatic read_frame(output logic [31:0] d,
                              output logic [31:0] lr,
                              output logic un);
        for (int k = 1; k < 32; k++) begin
            next_slot();
            d[32-k] = sdata;
            lr[k]   = lrclk;
        end
        next_slot();
        d[0]  = sdata;
        lr[0] = lrclk;
        un    = underrun;
    endtask

    task automatic test_reset();
        int rise1, fall1, rise2;
        logic un_at_fall;
        rise1 = 0; fall1 = 0; rise2 = 0; un_at_fall = 1'b0;
        rst   = 1'b1;
        valid = 1'b0;
        repeat (3) tick();
        checks++; if (bclk !== 1'b0) begin errors++; $display("FAIL rst_bclk: got %b want 0", bclk); end
        checks++; if (lrclk !== 1'b0) begin errors++; $display("FAIL rst_lrclk: got %b want 0", lrclk); end
        checks++; if (sdata !== 1'b0) begin errors++; $display("FAIL rst_sdata: got %b want 0", sdata); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %b want 0", underrun); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", ready); end
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (!prev_bclk && bclk) begin
                if (rise1 == 0) rise1 = e;
                else if (rise2 == 0) rise2 = e;
            end
            if (fell && fall1 == 0) begin
                fall1      = e;
                un_at_fall = underrun;
            end
        end
        checks++; if (rise1 != 2) begin errors++; $display("FAIL bclk_rise1: got %0d want 2", rise1); end
        checks++; if (fall1 != 4) begin errors++; $display("FAIL bclk_fall1: got %0d want 4", fall1); end
        checks++; if (rise2 != 6) begin errors++; $display("FAIL bclk_rise2: got %0d want 6", rise2); end
        checks++; if (un_at_fall !== 1'b1) begin errors++; $display("FAIL first_load_underrun: got %b want 1", un_at_fall); end
    endtask

    task automatic test_single();
        logic [31:0] d, lr;
        logic un;
        do_reset();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", ready); end
        write(16'hA5C3);
        next_slot();
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL single_load_underrun: got %b want 0", underrun); end
        checks++; if (sdata !== 1'b0) begin errors++; $display("FAIL single_slot0_sdata: got %b want 0", sdata); end
        checks++; if (lrclk !== 1'b0) begin errors++; $display("FAIL single_slot0_lrclk: got %b want 0", lrclk); end
        read_frame(d, lr, un);
        checks++; if (d !== 32'hA5C3A5C3) begin errors++; $display("FAIL single_data: got %h want a5c3a5c3", d); end
        checks++; if (lr !== 32'hFFFF0000) begin errors++; $display("FAIL single_lrclk: got %h want ffff0000", lr); end
        checks++; if (un !== 1'b1) begin errors++; $display("FAIL single_next_underrun: got %b want 1", un); end
    endtask

    task automatic test_underrun();
        logic [31:0] d, lr, exp2;
        logic un;
        do_reset();
        write(16'h7FFF);
        next_slot();
        un_cnt = 0;
        read_frame(d, lr, un);
        checks++; if (d !== 32'h7FFF7FFF) begin errors++; $display("FAIL ur_first_data: got %h want 7fff7fff", d); end
        checks++; if (un_cnt != 1) begin errors++; $display("FAIL ur_pulse_count: got %0d want 1", un_cnt); end
        read_frame(d, lr, un);
`ifdef I2S_TX_UNDERRUN_HOLD_EN
        exp2 = 32'h7FFF7FFF;
`else
        exp2 = 32'h0000_0000;
`endif
        checks++; if (d !== exp2) begin errors++; $display("FAIL ur_frame_data: got %h want %h", d, exp2); end
    endtask

    task automatic test_overflow();
        logic [31:0] d, lr;
        logic un;
        do_reset();
        next_slot();
        repeat (5) next_slot();
        ov_cnt    = 0;
        valid     = 1'b1;
        sample_in = 16'h1111;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ov_first_ready: got %b want 1", ready); end
        tick();
        sample_in = 16'h2222;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ov_second_ready: got %b want 0", ready); end
        tick();
        valid = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ov_pulse: got %b want 1", overflow); end
        tick();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ov_pulse_end: got %b want 0", overflow); end
        repeat (27) next_slot();
        checks++; if (ov_cnt != 1) begin errors++; $display("FAIL ov_count: got %0d want 1", ov_cnt); end
        read_frame(d, lr, un);
        checks++; if (d !== 32'h11111111) begin errors++; $display("FAIL ov_frame_data: got %h want 11111111", d); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d, lr;
        logic un;
        int n;
        do_reset();
        write(16'h0F0F);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(prev_bclk && bclk) && n < 8);
        valid     = 1'b1;
        sample_in = 16'h8000;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL sim_ready: got %b want 1", ready); end
        tick();
        valid = 1'b0;
        checks++; if (fell !== 1'b1) begin errors++; $display("FAIL sim_load_edge: got %b want 1", fell); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sim_overflow: got %b want 0", overflow); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL sim_underrun: got %b want 0", underrun); end
        read_frame(d, lr, un);
        checks++; if (d !== 32'h0F0F0F0F) begin errors++; $display("FAIL sim_frame1: got %h want 0f0f0f0f", d); end
        checks++; if (un !== 1'b0) begin errors++; $display("FAIL sim_frame2_underrun: got %b want 0", un); end
        read_frame(d, lr, un);
        checks++; if (d !== 32'h80008000) begin errors++; $display("FAIL sim_frame2: got %h want 80008000", d); end
    endtask

    task automatic test_midreset();
        logic [31:0] d, lr;
        logic un;
        do_reset();
        write(16'h1234);
        next_slot();
        repeat (10) next_slot();
        rst = 1'b1;
        tick();
        checks++; if (bclk !== 1'b0) begin errors++; $display("FAIL mr_bclk: got %b want 0", bclk); end
        checks++; if (lrclk !== 1'b0) begin errors++; $display("FAIL mr_lrclk: got %b want 0", lrclk); end
        checks++; if (sdata !== 1'b0) begin errors++; $display("FAIL mr_sdata: got %b want 0", sdata); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mr_ready: got %b want 1", ready); end
        checks++; if ({underrun, overflow} !== 2'b00) begin errors++; $display("FAIL mr_pulses: got %b want 00", {underrun, overflow}); end
        rst = 1'b0;
        write(16'hC3C3);
        next_slot();
        checks++; if (sdata !== 1'b0) begin errors++; $display("FAIL mr_slot0_sdata: got %b want 0", sdata); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL mr_underrun: got %b want 0", underrun); end
        read_frame(d, lr, un);
        checks++; if (d !== 32'hC3C3C3C3) begin errors++; $display("FAIL mr_frame: got %h want c3c3c3c3", d); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        un_cnt    = 0;
        ov_cnt    = 0;
        rst       = 1'b1;
        valid     = 1'b0;
        sample_in = '0;
        prev_bclk = 1'b0;
        fell      = 1'b0;
        test_reset();
        test_single();
        test_underrun();
        test_overflow();
        test_simultaneous();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
